// File: rtl/board_io_pkg.sv
// Shared layout constants and state type for the board input conditioning path.
package board_io_pkg;

   localparam int GPIO_IN_W = 32;
   localparam int SW_LSB    = 0;

   // Keys are packed directly above the switch field.
   function automatic int key_lsb(input int w_sw);
      return w_sw;
   endfunction

   typedef enum logic {PRIME, RUN} cond_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer followed by a tick-sampled debouncer.
module debounce_bit #(
   parameter int DEBOUNCE_TICKS = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic tick,
   input  logic prime,
   output logic level,
   output logic rise,
   output logic fall
);

   logic       sync_a;
   logic       sync_b;
   logic       stable;
   logic [3:0] cnt;
   logic       accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // The count already holds DEBOUNCE_TICKS-1 differing samples, so this tick completes the window.
   assign accept = tick && !prime && (sync_b != stable) && (cnt == 4'(DEBOUNCE_TICKS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= 4'd0;
      end else if (tick) begin
         if (prime) begin
            stable <= sync_b;
            cnt    <= 4'd0;
         end else if (sync_b != stable) begin
            if (cnt == 4'(DEBOUNCE_TICKS - 1)) begin
               stable <= sync_b;
               cnt    <= 4'd0;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end else begin
            cnt <= 4'd0;
         end
      end
   end

   assign level = stable;
   assign rise  = accept &  sync_b;
   assign fall  = accept & ~sync_b;

endmodule

// File: rtl/board_input_conditioner.sv
// Debounces board keys and switches into the SoC GPIO input word, with
// key press/release pulses and a write-1-to-clear sticky change register.
module board_input_conditioner
   import board_io_pkg::*;
#(
   parameter int W_KEY          = 4,
   parameter int W_SW           = 18,
   parameter int TICK_CYCLES    = 50000,
   parameter int DEBOUNCE_TICKS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [W_KEY-1:0]     key_n_i,
   input  logic [W_SW-1:0]      sw_i,
   output logic [GPIO_IN_W-1:0] gpio_in_o,
   output logic [W_KEY-1:0]     key_press_o,
   output logic [W_KEY-1:0]     key_release_o,
   output logic [GPIO_IN_W-1:0] event_o,
   input  logic [GPIO_IN_W-1:0] event_clr_i
);

   localparam int NB      = W_KEY + W_SW;
   localparam int KEY_LSB = key_lsb(W_SW);
   localparam int PW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   if (NB > GPIO_IN_W) begin : g_bad_width
      $error("board_input_conditioner: W_KEY + W_SW exceeds the GPIO word");
   end
   if (TICK_CYCLES < 2) begin : g_bad_tick
      $error("board_input_conditioner: TICK_CYCLES must be at least 2");
   end
   if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 15) begin : g_bad_deb
      $error("board_input_conditioner: DEBOUNCE_TICKS must be 2..15");
   end

   logic [PW-1:0]        presc;
   logic                 tick;
   cond_state_t          state;
   cond_state_t          state_next;
   logic [3:0]           prime_cnt;
   logic                 prime;
   logic [NB-1:0]        raw_bits;
   logic [NB-1:0]        level_vec;
   logic [NB-1:0]        rise_vec;
   logic [NB-1:0]        fall_vec;
   logic [GPIO_IN_W-1:0] set_vec;
   logic [GPIO_IN_W-1:0] event_q;

   always_ff @(posedge clk) begin
      if (reset || tick) presc <= '0;
      else               presc <= presc + PW'(1);
   end

   assign tick = (presc == PW'(TICK_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= PRIME;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset)                       prime_cnt <= 4'd0;
      else if (tick && state == PRIME) prime_cnt <= prime_cnt + 4'd1;
   end

   // PRIME lasts exactly DEBOUNCE_TICKS ticks; the last of them still copies levels silently.
   always_comb begin
      state_next = state;
      if (state == PRIME && tick && prime_cnt == 4'(DEBOUNCE_TICKS - 1)) state_next = RUN;
   end

   always_comb begin
      prime = (state == PRIME);
   end

   always_comb begin
      raw_bits                   = '0;
      raw_bits[SW_LSB +: W_SW]   = sw_i;
      raw_bits[KEY_LSB +: W_KEY] = ~key_n_i;
   end

   for (genvar g = 0; g < NB; g++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) u_debounce (
         .clk  (clk),
         .reset(reset),
         .raw  (raw_bits[g]),
         .tick (tick),
         .prime(prime),
         .level(level_vec[g]),
         .rise (rise_vec[g]),
         .fall (fall_vec[g])
      );
   end

   always_comb begin
      set_vec         = '0;
      set_vec[NB-1:0] = rise_vec | fall_vec;
   end

   // Set is ORed in after the clear so a same-cycle clear never hides a fresh change.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_press_o   <= '0;
         key_release_o <= '0;
         event_q       <= '0;
      end else begin
         key_press_o   <= rise_vec[KEY_LSB +: W_KEY];
         key_release_o <= fall_vec[KEY_LSB +: W_KEY];
         event_q       <= (event_q & ~event_clr_i) | set_vec;
      end
   end

   always_comb begin
      gpio_in_o         = '0;
      gpio_in_o[NB-1:0] = level_vec;
   end

   assign event_o = event_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Self-checking bench for board_input_conditioner: vector table, hand-written
// corner sequences and randomized stimulus against a sample-history model.
module tb_board_input_conditioner;

   localparam int W_KEY = 4;
   localparam int W_SW  = 18;
   localparam int TICK  = 4;
   localparam int DEB   = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key_n_i;
   logic [17:0] sw_i;
   logic [31:0] event_clr_i;
   logic [31:0] gpio_in_o;
   logic [3:0]  key_press_o;
   logic [3:0]  key_release_o;
   logic [31:0] event_o;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   board_input_conditioner #(
      .W_KEY(W_KEY),
      .W_SW(W_SW),
      .TICK_CYCLES(TICK),
      .DEBOUNCE_TICKS(DEB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .key_n_i(key_n_i),
      .sw_i(sw_i),
      .gpio_in_o(gpio_in_o),
      .key_press_o(key_press_o),
      .key_release_o(key_release_o),
      .event_o(event_o),
      .event_clr_i(event_clr_i)
   );

   // Reference model: a bit flips once its last DEB tick samples all disagree with its level.
   logic [31:0] m_past1, m_past2, m_stable, m_event;
   logic [31:0] m_hist [DEB];
   logic [3:0]  m_press, m_release;
   int          m_k, m_ticks;

   task automatic model_update();
      logic [31:0] raw, sample, accept, all_diff;
      raw    = {10'b0, ~key_n_i, sw_i};
      accept = '0;
      if (reset) begin
         m_past1 = '0; m_past2 = '0; m_stable = '0; m_event = '0;
         m_press = '0; m_release = '0; m_k = 0; m_ticks = 0;
         for (int j = 0; j < DEB; j++) m_hist[j] = '0;
         return;
      end
      sample = m_past2;
      if ((m_k % TICK) == TICK - 1) begin
         for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = sample;
         if (m_ticks < DEB) begin
            m_stable = sample;
         end else begin
            all_diff = '1;
            for (int j = 0; j < DEB; j++) all_diff &= (m_hist[j] ^ m_stable);
            accept   = all_diff;
            m_stable = m_stable ^ accept;
         end
         m_ticks++;
      end
      m_press   = accept[21:18] &  m_stable[21:18];
      m_release = accept[21:18] & ~m_stable[21:18];
      m_event   = (m_event & ~event_clr_i) | accept;
      m_past2   = m_past1;
      m_past1   = raw;
      m_k++;
   endtask

   function automatic logic accept_next(input int b);
      if (reset) return 1'b0;
      if ((m_k % TICK) != TICK - 1) return 1'b0;
      if (m_ticks < DEB) return 1'b0;
      if (m_past2[b] == m_stable[b]) return 1'b0;
      for (int j = 0; j < DEB - 1; j++)
         if (m_hist[j][b] == m_stable[b]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_output("model_gpio", gpio_in_o, m_stable);
      check_output("model_event", event_o, m_event);
      check_output("model_pulses", {24'b0, key_press_o, key_release_o}, {24'b0, m_press, m_release});
   endtask

   task automatic apply_stimulus(input logic [3:0] k, input logic [17:0] s, input logic [31:0] c);
      key_n_i     = k;
      sw_i        = s;
      event_clr_i = c;
   endtask

   typedef struct {
      logic [3:0]  key_n;
      logic [17:0] sw;
      logic [31:0] clr;
      int          hold;
      logic [31:0] exp_gpio;
      logic [31:0] exp_event;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          rise_at, press_cnt, found, transitions, hold;
      logic        prev0, race;
      logic [31:0] snap_g, snap_e;

      vecs[0] = '{4'hF, 18'h00020, 32'h0,          16, 32'h0000_0020, 32'h0000_0000};
      vecs[1] = '{4'hD, 18'h00020, 32'h0,          20, 32'h0008_0020, 32'h0008_0000};
      vecs[2] = '{4'hD, 18'h00020, 32'h0008_0000,   2, 32'h0008_0020, 32'h0000_0000};
      vecs[3] = '{4'hF, 18'h00020, 32'h0,          20, 32'h0000_0020, 32'h0008_0000};
      vecs[4] = '{4'hF, 18'h00021, 32'h0,          20, 32'h0000_0021, 32'h0008_0001};
      vecs[5] = '{4'hF, 18'h00021, 32'hFFFF_FFFF,   1, 32'h0000_0021, 32'h0000_0000};
      vecs[6] = '{4'h6, 18'h3FFFF, 32'h0,          20, 32'h0027_FFFF, 32'h0027_FFDE};

      reset = 1'b1;
      apply_stimulus(4'hF, 18'h00020, 32'h0);
      repeat (5) step();
      check_output("reset_gpio", gpio_in_o, 32'h0);
      check_output("reset_event", event_o, 32'h0);
      check_output("reset_pulses", {24'b0, key_press_o, key_release_o}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         apply_stimulus(vecs[i].key_n, vecs[i].sw, vecs[i].clr);
         repeat (vecs[i].hold) step();
         check_output($sformatf("vec%0d_gpio", i), gpio_in_o, vecs[i].exp_gpio);
         check_output($sformatf("vec%0d_event", i), event_o, vecs[i].exp_event);
      end

      apply_stimulus(4'hF, 18'h0, 32'h0);
      repeat (20) step();
      event_clr_i = 32'hFFFF_FFFF;
      step();
      event_clr_i = 32'h0;

      // Press key 1 and hold: single pulse, bounded latency, sticky event.
      key_n_i   = 4'b1101;
      rise_at   = -1;
      press_cnt = 0;
      for (int c = 1; c <= 25; c++) begin
         step();
         if (key_press_o == 4'b0010) press_cnt++;
         else if (key_press_o != 4'b0000) press_cnt += 100;
         if (rise_at < 0 && gpio_in_o[19]) rise_at = c;
      end
      check_output("press_latency_le_15", 32'(rise_at >= 1 && rise_at <= 15), 32'd1);
      check_output("press_pulse_count", 32'(press_cnt), 32'd1);
      repeat (10) step();
      check_output("press_event19_sticky", 32'(event_o[19]), 32'd1);

      // Release key 1 with a clear landing on the acceptance edge.
      key_n_i = 4'hF;
      found   = 0;
      for (int c = 0; c < 30 && found == 0; c++) begin
         race        = accept_next(19);
         event_clr_i = race ? 32'h0008_0000 : 32'h0;
         step();
         if (race) begin
            found = 1;
            check_output("race_event19", 32'(event_o[19]), 32'd1);
            check_output("race_release", 32'(key_release_o), 32'h2);
         end
      end
      check_output("race_found", 32'(found), 32'd1);
      event_clr_i = 32'h0008_0000;
      step();
      check_output("late_clear_event19", 32'(event_o[19]), 32'd0);
      event_clr_i = 32'h0;

      // Three-cycle glitch on key 2 must never be accepted.
      snap_g    = gpio_in_o;
      snap_e    = event_o;
      press_cnt = 0;
      key_n_i   = 4'b1011;
      repeat (3) begin step(); if (key_press_o != 0) press_cnt++; end
      key_n_i = 4'hF;
      repeat (20) begin step(); if (key_press_o != 0) press_cnt++; end
      check_output("glitch_gpio", gpio_in_o, snap_g);
      check_output("glitch_event", event_o, snap_e);
      check_output("glitch_pulses", 32'(press_cnt), 32'd0);

      // Bouncing switch 0 settles to one clean rise.
      transitions = 0;
      prev0       = gpio_in_o[0];
      for (int c = 0; c < 40; c++) begin
         if (c % 3 == 0) sw_i[0] = ~sw_i[0];
         step();
         if (gpio_in_o[0] != prev0) transitions++;
         prev0 = gpio_in_o[0];
      end
      sw_i[0] = 1'b1;
      repeat (20) begin
         step();
         if (gpio_in_o[0] != prev0) transitions++;
         prev0 = gpio_in_o[0];
      end
      check_output("bounce_transitions", 32'(transitions), 32'd1);
      check_output("bounce_final", 32'(gpio_in_o[0]), 32'd1);

      // Reset eight cycles into a press; priming must adopt the held key silently.
      key_n_i = 4'b1101;
      repeat (8) step();
      reset = 1'b1;
      step();
      check_output("midreset_gpio", gpio_in_o, 32'h0);
      check_output("midreset_event", event_o, 32'h0);
      check_output("midreset_pulses", {24'b0, key_press_o, key_release_o}, 32'h0);
      reset     = 1'b0;
      press_cnt = 0;
      repeat (20) begin step(); if (key_press_o != 0) press_cnt++; end
      check_output("reprime_gpio", gpio_in_o, 32'h0008_0001);
      check_output("reprime_event", event_o, 32'h0);
      check_output("reprime_pulses", 32'(press_cnt), 32'd0);

      for (int seg = 0; seg < 80; seg++) begin
         key_n_i = 4'($urandom);
         sw_i    = 18'($urandom);
         hold    = $urandom_range(1, 30);
         for (int h = 0; h < hold; h++) begin
            event_clr_i = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            reset       = ($urandom_range(0, 99) == 0);
            step();
         end
         reset = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
